// File: rtl/pht_ctrl_pkg.sv
// Shared predictor types for the pattern-history-table controller.
// pht_idx_t is the table index / global-history width; ckpt_t is the
// checkpoint recorded for every in-flight predicted branch.
package pht_ctrl_pkg;

  // Table has 16 counters, so index and history are both 4 bits wide.
  localparam int PHT_HIST_W = 4;

  typedef logic [PHT_HIST_W-1:0] pht_idx_t;

  // Checkpoint of one predicted branch:
  //   idx  - table index used for the lookup (counter to train later)
  //   pred - direction returned to fetch
  //   ghr  - speculative history *before* this branch was shifted in,
  //          so a mispredict can rebuild history from this point
  typedef struct packed {
    pht_idx_t idx;
    logic     pred;
    pht_idx_t ghr;
  } ckpt_t;

  // Shift one outcome into the low end of a history register.
  function automatic pht_idx_t ghr_shift(input pht_idx_t ghr, input logic bit_in);
    return {ghr[PHT_HIST_W-2:0], bit_in};
  endfunction

endpackage

// File: rtl/bp_ckpt_fifo.sv
// Checkpoint FIFO for in-flight predicted branches.
// Synchronous, power-of-two depth, head entry visible combinationally on dout.
// clear wins over push and pop in the same cycle; the head is still readable
// that cycle so the caller can consume it before the wipe takes effect.
// push while full and pop while empty are ignored.
module bp_ckpt_fifo
  import pht_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  ckpt_t         din,
  output ckpt_t         dout,
  output logic          empty,
  output logic [CW-1:0] count
);

  ckpt_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pht_ctrl.sv
// Gshare branch-prediction controller for a 16-entry two-bit-counter table.
// Forms the lookup index at IF, checkpoints each prediction, and at EX issues
// the registered counter update and repairs global history on mispredict.
// Optional build macro: PHT_CTRL_STATS_EN adds saturating stat_pred/stat_miss.
//
// Handshake: IF_valid is a request; IF_stall is its inverse-ready. A branch is
// accepted only in a cycle with IF_valid=1 and IF_stall=0 (and no flush or
// mispredict squashing it); fetch must hold the branch otherwise. EX_valid has
// no ready: it always refers to the oldest in-flight branch and is consumed
// the cycle it is asserted.
module pht_ctrl
  import pht_ctrl_pkg::*;
#(
  parameter int HIST_W     = PHT_HIST_W,  // must equal the table index width
  parameter int FIFO_DEPTH = 4,           // power of two, >= 2
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              IF_valid,
  input  logic [HIST_W-1:0] IF_pc_bits,
  input  logic              pht_prediction,
  output logic [HIST_W-1:0] pht_idx,
  output logic              IF_pred_taken,
  output logic              IF_stall,
  input  logic              EX_valid,
  input  logic              EX_taken,
  input  logic              flush,
  output logic              pht_load,
  output logic [HIST_W-1:0] EX_pht_idx,
  output logic              EX_branch_flag,
  output logic              mispredict,
  output logic              resolve_err
`ifdef PHT_CTRL_STATS_EN
  ,
  output logic [15:0]       stat_pred,
  output logic [15:0]       stat_miss
`endif
);

  pht_idx_t      spec_ghr;
  pht_idx_t      commit_ghr;
  pht_idx_t      spec_ghr_nxt;
  pht_idx_t      commit_ghr_nxt;
  ckpt_t         head;
  ckpt_t         push_ckpt;
  logic          fifo_empty;
  logic [CW-1:0] count;
  logic          push_req;
  logic          pop_req;
  logic          mis_now;
  logic          fifo_push;
  logic          fifo_clear;

  // Lookup path: purely combinational every cycle.
  assign pht_idx       = IF_pc_bits ^ spec_ghr;
  assign IF_pred_taken = pht_prediction;
  assign IF_stall      = (count == CW'(FIFO_DEPTH));

  // A fetched branch is accepted into the window unless the window is full.
  assign push_req  = IF_valid && !IF_stall;
  assign pop_req   = EX_valid && !fifo_empty;
  assign mis_now   = pop_req && (head.pred != EX_taken);

  // Mispredict and flush both squash everything younger, including a
  // branch arriving this very cycle.
  assign fifo_clear = mis_now || flush;
  assign fifo_push  = push_req && !fifo_clear;

  assign push_ckpt.idx  = pht_idx;
  assign push_ckpt.pred = pht_prediction;
  assign push_ckpt.ghr  = spec_ghr;

  bp_ckpt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (pop_req),
    .clear   (fifo_clear),
    .din     (push_ckpt),
    .dout    (head),
    .empty   (fifo_empty),
    .count   (count)
  );

  // Next-state for both history registers. Mispredict rebuilds from the
  // head checkpoint; flush falls back to committed history (after this
  // cycle's resolution); otherwise an accepted push shifts its prediction in.
  always_comb begin
    commit_ghr_nxt = commit_ghr;
    spec_ghr_nxt   = spec_ghr;
    if (pop_req) begin
      commit_ghr_nxt = ghr_shift(commit_ghr, EX_taken);
    end
    if (mis_now) begin
      spec_ghr_nxt = ghr_shift(head.ghr, EX_taken);
    end else if (flush) begin
      spec_ghr_nxt = commit_ghr_nxt;
    end else if (fifo_push) begin
      spec_ghr_nxt = ghr_shift(spec_ghr, pht_prediction);
    end
  end

  // History registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      spec_ghr   <= '0;
      commit_ghr <= '0;
    end else begin
      spec_ghr   <= spec_ghr_nxt;
      commit_ghr <= commit_ghr_nxt;
    end
  end

  // Registered table update and status: one-cycle pulses after resolution.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pht_load       <= 1'b0;
      EX_pht_idx     <= '0;
      EX_branch_flag <= 1'b0;
      mispredict     <= 1'b0;
      resolve_err    <= 1'b0;
    end else begin
      pht_load   <= pop_req;
      mispredict <= mis_now;
      if (pop_req) begin
        EX_pht_idx     <= head.idx;
        EX_branch_flag <= EX_taken;
      end
      if (EX_valid && fifo_empty) begin
        resolve_err <= 1'b1;
      end
    end
  end

`ifdef PHT_CTRL_STATS_EN
  // Saturating event counters: accepted pushes and mispredict pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_pred <= '0;
      stat_miss <= '0;
    end else begin
      if (fifo_push && (stat_pred != 16'hFFFF)) stat_pred <= stat_pred + 16'd1;
      if (mis_now   && (stat_miss != 16'hFFFF)) stat_miss <= stat_miss + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pht_ctrl.sv
// Directed bench for pht_ctrl: reset state, lookup/push, resolution update,
// full-window stall, mispredict repair, push+pop, flush+pop and resolve_err.
module tb_pht_ctrl;
  import pht_ctrl_pkg::*;

  localparam int HIST_W = 4;
  localparam int UW     = HIST_W + 1;

  logic              clk;
  logic              reset_n;
  logic              IF_valid;
  logic [HIST_W-1:0] IF_pc_bits;
  logic              pht_prediction;
  logic [HIST_W-1:0] pht_idx;
  logic              IF_pred_taken;
  logic              IF_stall;
  logic              EX_valid;
  logic              EX_taken;
  logic              flush;
  logic              pht_load;
  logic [HIST_W-1:0] EX_pht_idx;
  logic              EX_branch_flag;
  logic              mispredict;
  logic              resolve_err;
`ifdef PHT_CTRL_STATS_EN
  logic [15:0]       stat_pred;
  logic [15:0]       stat_miss;
`endif

  int checks   = 0;
  int failures = 0;

  // Expected table updates {idx, direction}, in issue order.
  logic [UW-1:0] exp_q[$];

  pht_ctrl #(.HIST_W(HIST_W), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .IF_valid       (IF_valid),
    .IF_pc_bits     (IF_pc_bits),
    .pht_prediction (pht_prediction),
    .pht_idx        (pht_idx),
    .IF_pred_taken  (IF_pred_taken),
    .IF_stall       (IF_stall),
    .EX_valid       (EX_valid),
    .EX_taken       (EX_taken),
    .flush          (flush),
    .pht_load       (pht_load),
    .EX_pht_idx     (EX_pht_idx),
    .EX_branch_flag (EX_branch_flag),
    .mispredict     (mispredict),
    .resolve_err    (resolve_err)
`ifdef PHT_CTRL_STATS_EN
    ,
    .stat_pred      (stat_pred),
    .stat_miss      (stat_miss)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic idle();
    IF_valid       = 1'b0;
    IF_pc_bits     = '0;
    pht_prediction = 1'b0;
    EX_valid       = 1'b0;
    EX_taken       = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Read speculative history through the lookup path (pc bits = 0).
  task automatic check_spec(input string tag, input logic [HIST_W-1:0] exp);
    IF_pc_bits = '0;
    #1;
    check(tag, 16'(pht_idx), 16'(exp));
  endtask

  // Scoreboard: every table update must match the oldest expected one.
  always @(negedge clk) begin
    if (pht_load === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $error("FAIL unexpected_load observed=%0h expected=none", {EX_pht_idx, EX_branch_flag});
      end else begin
        logic [UW-1:0] e;
        e = exp_q.pop_front();
        assert ({EX_pht_idx, EX_branch_flag} === e) else begin
          failures++;
          $error("FAIL update observed=%0h expected=%0h", {EX_pht_idx, EX_branch_flag}, e);
        end
      end
    end
  end

  initial begin
    do_reset();
    #1;
    // Reset state
    check("rst_pht_load",   16'(pht_load), 16'h0);
    check("rst_mispredict", 16'(mispredict), 16'h0);
    check("rst_resolve_err", 16'(resolve_err), 16'h0);
    check("rst_ex_idx",     16'(EX_pht_idx), 16'h0);
    check("rst_ex_flag",    16'(EX_branch_flag), 16'h0);
    check("rst_stall",      16'(IF_stall), 16'h0);
    check("rst_count",      16'(dut.count), 16'h0);
    check_spec("rst_spec_ghr", 4'h0);

    // Lookup + push: pc=A, ghr=0 -> idx A; history becomes 1
    IF_valid = 1'b1; IF_pc_bits = 4'hA; pht_prediction = 1'b1;
    #1;
    check("lookup_idx", 16'(pht_idx), 16'hA);
    check("lookup_pred", 16'(IF_pred_taken), 16'h1);
    tick();
    idle();
    check_spec("push_spec_ghr", 4'h1);
    check("push_count", 16'(dut.count), 16'h1);

    // Correct resolution -> update {A,1}, commit history 1
    EX_valid = 1'b1; EX_taken = 1'b1;
    exp_q.push_back({4'hA, 1'b1});
    tick();
    idle();
    check("res_load", 16'(pht_load), 16'h1);
    check("res_idx", 16'(EX_pht_idx), 16'hA);
    check("res_flag", 16'(EX_branch_flag), 16'h1);
    check("res_mispredict", 16'(mispredict), 16'h0);
    check("res_commit_ghr", 16'(dut.commit_ghr), 16'h1);
    check("res_count", 16'(dut.count), 16'h0);
    tick();
    check("res_load_pulse", 16'(pht_load), 16'h0);

    // Fill: four not-taken predictions, ghr 1->2->4->8->0; idx = 1,2,4,8
    for (int i = 0; i < 4; i++) begin
      IF_valid = 1'b1; IF_pc_bits = '0; pht_prediction = 1'b0;
      tick();
    end
    idle();
    #1;
    check("full_stall", 16'(IF_stall), 16'h1);
    check("full_count", 16'(dut.count), 16'h4);
    check_spec("full_spec_ghr", 4'h0);
    // Fifth branch while full is ignored
    IF_valid = 1'b1; IF_pc_bits = 4'h7; pht_prediction = 1'b1;
    tick();
    idle();
    check_spec("full_ignored_spec", 4'h0);
    check("full_ignored_count", 16'(dut.count), 16'h4);

    // Resolve oldest correctly (idx 1, pred 0): commit 1 -> 2
    EX_valid = 1'b1; EX_taken = 1'b0;
    exp_q.push_back({4'h1, 1'b0});
    tick();
    idle();
    check("ok_mispredict", 16'(mispredict), 16'h0);
    check("ok_count", 16'(dut.count), 16'h3);
    check("ok_commit_ghr", 16'(dut.commit_ghr), 16'h2);

    // Three in flight; head idx 2, pred 0, ghr 2. Taken -> mispredict,
    // spec = {010,1} = 5; same-cycle push discarded.
    EX_valid = 1'b1; EX_taken = 1'b1;
    IF_valid = 1'b1; IF_pc_bits = 4'h3; pht_prediction = 1'b1;
    exp_q.push_back({4'h2, 1'b1});
    tick();
    idle();
    check("mis_pulse", 16'(mispredict), 16'h1);
    check("mis_count", 16'(dut.count), 16'h0);
    check("mis_commit_ghr", 16'(dut.commit_ghr), 16'h5);
    check_spec("mis_spec_ghr", 4'h5);
    tick();
    check("mis_pulse_end", 16'(mispredict), 16'h0);
    check("mis_single_load", 16'(pht_load), 16'h0);

    // Push (idx 5, pred 1): spec 5 -> B
    IF_valid = 1'b1; IF_pc_bits = '0; pht_prediction = 1'b1;
    tick();
    // Push (idx B, pred 0) with correct pop of idx 5: spec B -> 6, commit -> B
    IF_valid = 1'b1; IF_pc_bits = '0; pht_prediction = 1'b0;
    EX_valid = 1'b1; EX_taken = 1'b1;
    exp_q.push_back({4'h5, 1'b1});
    tick();
    idle();
    check("pp_count", 16'(dut.count), 16'h1);
    check("pp_mispredict", 16'(mispredict), 16'h0);
    check("pp_commit_ghr", 16'(dut.commit_ghr), 16'hB);
    check_spec("pp_spec_ghr", 4'h6);

    // Push (idx 6, pred 1): spec 6 -> D, two in flight
    IF_valid = 1'b1; IF_pc_bits = '0; pht_prediction = 1'b1;
    tick();
    idle();
    check("pre_flush_count", 16'(dut.count), 16'h2);
    // Flush + correct pop of idx B (pred 0) + push: commit B -> 6, spec -> 6
    flush = 1'b1; EX_valid = 1'b1; EX_taken = 1'b0;
    IF_valid = 1'b1; IF_pc_bits = 4'h9; pht_prediction = 1'b1;
    exp_q.push_back({4'hB, 1'b0});
    tick();
    idle();
    check("flush_load", 16'(pht_load), 16'h1);
    check("flush_mispredict", 16'(mispredict), 16'h0);
    check("flush_count", 16'(dut.count), 16'h0);
    check("flush_commit_ghr", 16'(dut.commit_ghr), 16'h6);
    check_spec("flush_spec_ghr", 4'h6);

`ifdef PHT_CTRL_STATS_EN
    check("stat_pred", stat_pred, 16'd8);
    check("stat_miss", stat_miss, 16'd1);
`endif

    // Resolution with empty window
    EX_valid = 1'b1; EX_taken = 1'b1;
    tick();
    idle();
    check("err_no_load", 16'(pht_load), 16'h0);
    check("err_set", 16'(resolve_err), 16'h1);
    check("err_commit_hold", 16'(dut.commit_ghr), 16'h6);
    tick();
    tick();
    check("err_sticky", 16'(resolve_err), 16'h1);
    do_reset();
    #1;
    check("err_cleared", 16'(resolve_err), 16'h0);
    check_spec("rst2_spec_ghr", 4'h0);

    check("pending_updates", 16'(exp_q.size()), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
